// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory pipeline stage:
//   - mem_state_e : FSM state encoding (IDLE=0, ACCESS=1)
//   - exmem_t     : contents of the EXE/MEM pipeline register
//   - WAIT_MAX_DEFAULT : default number of unanswered ACCESS cycles before timeout
//   - is_mem_op() : true when an instruction needs the data memory
// -----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_e;

    localparam int unsigned WAIT_MAX_DEFAULT = 32'd15;

    // Everything the execute stage hands over, captured as one word.
    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic        branch;
        logic        zero;
        logic [31:0] aluR;
        logic [31:0] inB;
        logic [31:0] pc;
        logic [4:0]  destR;
        logic [3:0]  ins_type;
        logic [3:0]  ins_number;
    } exmem_t;

    // Loads and stores both occupy the data memory.
    function automatic logic is_mem_op(input logic m2reg, input logic wmem);
        return m2reg | wmem;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if
// Data-memory request/response bundle between the memory stage and the memory.
//   dmem_req   : request valid (memory stage -> memory)
//   dmem_we    : write enable
//   dmem_addr  : byte address
//   dmem_wdata : store data
//   dmem_rdata : load data (memory -> memory stage)
//   dmem_ready : completion of the current request
// master = memory stage, slave = memory.
// -----------------------------------------------------------------------------
interface mem_stage_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ready
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ready
    );

endinterface

// File: rtl/Reg_EXE_MEM.sv
// -----------------------------------------------------------------------------
// Reg_EXE_MEM
// EXE/MEM pipeline register. Loads i_d on a rising edge while i_en=1,
// otherwise holds. Cleared asynchronously while rst=0.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   i_en : load enable (the stage is not stalled)
//   i_d  : execute-stage bundle
//   o_q  : registered bundle
// -----------------------------------------------------------------------------
module Reg_EXE_MEM
    import mem_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_en,
    input  exmem_t i_d,
    output exmem_t o_q
);

    exmem_t r_q;

    // Pipeline register: capture when enabled, hold while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory pipeline stage. Captures the execute-stage result, runs a two-state
// FSM (IDLE/ACCESS) that issues loads and stores on the data-memory bus and
// stalls the pipeline until the memory answers or a wait counter expires.
// A timeout returns to IDLE, sets the sticky mem_err flag and suppresses the
// register write of the timed-out instruction only.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   ex_*, EXE_ins_*     : execute-stage control, data and debug tags
//   dmem (master)       : data-memory request/response bundle
//   mem_wreg/m2reg/aluR/mdata/destR : writeback bundle
//   mem_pcsrc/branch_pc : taken-branch select and target
//   mem_stall           : hold upstream stages
//   mem_valid           : writeback may capture this cycle
//   mem_err             : sticky memory-timeout flag
//   MEM_ins_*           : debug tags
// Parameter WAIT_MAX (1..255): ACCESS cycles without dmem_ready before timeout.
// -----------------------------------------------------------------------------
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_wreg,
    input  logic        ex_m2reg,
    input  logic        ex_wmem,
    input  logic        ex_branch,
    input  logic        ex_zero,
    input  logic [31:0] ex_aluR,
    input  logic [31:0] ex_inB,
    input  logic [31:0] ex_pc,
    input  logic [4:0]  ex_destR,
    input  logic [3:0]  EXE_ins_type,
    input  logic [3:0]  EXE_ins_number,
    mem_stage_if.master dmem,
    output logic        mem_wreg,
    output logic        mem_m2reg,
    output logic [31:0] mem_aluR,
    output logic [31:0] mem_mdata,
    output logic [4:0]  mem_destR,
    output logic        mem_pcsrc,
    output logic [31:0] mem_branch_pc,
    output logic        mem_stall,
    output logic        mem_valid,
    output logic        mem_err,
    output logic [3:0]  MEM_ins_type,
    output logic [3:0]  MEM_ins_number
);

    // Counter value seen in the last allowed ACCESS cycle; an unanswered
    // cycle at this value is the WAIT_MAX-th one.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 32'd1);

    mem_state_e  r_state;
    mem_state_e  w_state_nxt;
    logic [7:0]  r_wait;
    logic [7:0]  w_wait_nxt;
    logic        r_err;
    logic        w_err_nxt;
    logic        r_kill;
    logic        w_kill_nxt;
    logic [31:0] r_mdata;
    logic [31:0] w_mdata_nxt;

    exmem_t      w_ex;
    exmem_t      w_q;
    logic        w_stall;

    assign w_ex = '{
        wreg:       ex_wreg,
        m2reg:      ex_m2reg,
        wmem:       ex_wmem,
        branch:     ex_branch,
        zero:       ex_zero,
        aluR:       ex_aluR,
        inB:        ex_inB,
        pc:         ex_pc,
        destR:      ex_destR,
        ins_type:   EXE_ins_type,
        ins_number: EXE_ins_number
    };

    assign w_stall = (r_state == ACCESS);

    Reg_EXE_MEM u_reg_exe_mem (
        .clk  (clk),
        .rst  (rst),
        .i_en (~w_stall),
        .i_d  (w_ex),
        .o_q  (w_q)
    );

    // FSM, wait counter, error/kill flags and load-data next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_err_nxt   = r_err;
        w_kill_nxt  = r_kill;
        w_mdata_nxt = r_mdata;
        case (r_state)
            IDLE: begin
                // This edge captures a new instruction, so any suppression
                // belonging to the previous one ends here.
                w_kill_nxt = 1'b0;
                if (is_mem_op(ex_m2reg, ex_wmem)) begin
                    w_state_nxt = ACCESS;
                    w_wait_nxt  = 8'd0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ACCESS: begin
                // Ready is tested first so it beats a simultaneous timeout.
                if (dmem.dmem_ready) begin
                    w_state_nxt = IDLE;
                    if (w_q.m2reg) begin
                        w_mdata_nxt = dmem.dmem_rdata;
                    end else begin
                        w_mdata_nxt = r_mdata;
                    end
                end else if (r_wait == WAIT_LAST) begin
                    w_state_nxt = IDLE;
                    w_err_nxt   = 1'b1;
                    w_kill_nxt  = 1'b1;
                    w_wait_nxt  = r_wait + 8'd1;
                end else begin
                    w_wait_nxt  = r_wait + 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counter and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_wait  <= 8'd0;
            r_err   <= 1'b0;
            r_kill  <= 1'b0;
            r_mdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
            r_err   <= w_err_nxt;
            r_kill  <= w_kill_nxt;
            r_mdata <= w_mdata_nxt;
        end
    end

    // Memory bus is driven only during ACCESS and is all-zero otherwise.
    assign dmem.dmem_req   = w_stall;
    assign dmem.dmem_we    = w_stall & w_q.wmem;
    assign dmem.dmem_addr  = w_stall ? w_q.aluR : 32'd0;
    assign dmem.dmem_wdata = w_stall ? w_q.inB  : 32'd0;

    assign mem_wreg       = w_q.wreg & ~r_kill;
    assign mem_m2reg      = w_q.m2reg;
    assign mem_aluR       = w_q.aluR;
    assign mem_mdata      = r_mdata;
    assign mem_destR      = w_q.destR;
    assign mem_pcsrc      = w_q.branch & w_q.zero;
    assign mem_branch_pc  = w_q.pc;
    assign mem_stall      = w_stall;
    // Gated by reset so that valid, like every other output, is low while
    // the block is held in reset.
    assign mem_valid      = rst & ~w_stall;
    assign mem_err        = r_err;
    assign MEM_ins_type   = w_q.ins_type;
    assign MEM_ins_number = w_q.ins_number;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage (WAIT_MAX=4). Each instruction is driven
// while the stage is not stalled; while stalled the execute inputs carry junk
// to prove the pipeline register holds. A per-instruction reference model
// predicts stall length, write suppression, load data and the error flag.
// -----------------------------------------------------------------------------
module tb_mem_stage;
    import mem_pkg::*;

    localparam int WMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_wreg, ex_m2reg, ex_wmem, ex_branch, ex_zero;
    logic [31:0] ex_aluR, ex_inB, ex_pc;
    logic [4:0]  ex_destR;
    logic [3:0]  EXE_ins_type, EXE_ins_number;
    logic        mem_wreg, mem_m2reg, mem_pcsrc, mem_stall, mem_valid, mem_err;
    logic [31:0] mem_aluR, mem_mdata, mem_branch_pc;
    logic [4:0]  mem_destR;
    logic [3:0]  MEM_ins_type, MEM_ins_number;

    mem_stage_if dif ();

    mem_stage #(.WAIT_MAX(WMAX)) dut (
        .clk(clk), .rst(rst),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
        .ex_branch(ex_branch), .ex_zero(ex_zero),
        .ex_aluR(ex_aluR), .ex_inB(ex_inB), .ex_pc(ex_pc), .ex_destR(ex_destR),
        .EXE_ins_type(EXE_ins_type), .EXE_ins_number(EXE_ins_number),
        .dmem(dif),
        .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_aluR(mem_aluR),
        .mem_mdata(mem_mdata), .mem_destR(mem_destR), .mem_pcsrc(mem_pcsrc),
        .mem_branch_pc(mem_branch_pc), .mem_stall(mem_stall), .mem_valid(mem_valid),
        .mem_err(mem_err), .MEM_ins_type(MEM_ins_type), .MEM_ins_number(MEM_ins_number)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        wreg, m2reg, wmem, branch, zero;
        logic [31:0] aluR, inB, pc, rdata;
        logic [4:0]  destR;
        logic [3:0]  typ, num;
        int          ready_at;   // ACCESS cycle with ready=1; 0 = never
    } ins_t;

    typedef struct {
        int          stall;
        logic        acc_req, acc_we;
        logic [31:0] acc_addr, acc_wdata;
        logic        valid, wreg, m2reg, pcsrc, err, req_after;
        logic [31:0] aluR, mdata, bpc;
        logic [4:0]  destR;
        logic [3:0]  typ, num;
    } obs_t;

    // Reference model state.
    logic [31:0] m_mdata;
    logic        m_err;

    // Model: a memory op stalls until ready or WMAX cycles, whichever first.
    task automatic model_step(input ins_t in, output int e_stall, output logic e_wreg);
        if (!(in.m2reg || in.wmem)) begin
            e_stall = 0;
            e_wreg  = in.wreg;
        end else if (in.ready_at >= 1 && in.ready_at <= WMAX) begin
            e_stall = in.ready_at;
            e_wreg  = in.wreg;
            if (in.m2reg) m_mdata = in.rdata;
        end else begin
            e_stall = WMAX;
            e_wreg  = 1'b0;
            m_err   = 1'b1;
        end
    endtask

    task automatic drive(input ins_t in);
        ex_wreg = in.wreg; ex_m2reg = in.m2reg; ex_wmem = in.wmem;
        ex_branch = in.branch; ex_zero = in.zero;
        ex_aluR = in.aluR; ex_inB = in.inB; ex_pc = in.pc; ex_destR = in.destR;
        EXE_ins_type = in.typ; EXE_ins_number = in.num;
    endtask

    task automatic drive_junk();
        ex_wreg = 1'($urandom); ex_m2reg = 1'($urandom); ex_wmem = 1'($urandom);
        ex_branch = 1'($urandom); ex_zero = 1'($urandom);
        ex_aluR = $urandom; ex_inB = $urandom; ex_pc = $urandom; ex_destR = 5'($urandom);
        EXE_ins_type = 4'($urandom); EXE_ins_number = 4'($urandom);
    endtask

    function automatic ins_t mk(input int kind);
        ins_t t;
        t.wreg = 1'($urandom); t.m2reg = 1'b0; t.wmem = 1'b0;
        t.branch = 1'b0; t.zero = 1'($urandom);
        t.aluR = $urandom; t.inB = $urandom; t.pc = $urandom; t.rdata = $urandom;
        t.destR = 5'($urandom); t.typ = 4'($urandom); t.num = 4'($urandom);
        t.ready_at = $urandom_range(0, WMAX + 1);
        case (kind)
            1: begin t.m2reg = 1'b1; t.wreg = 1'b1; end
            2: begin t.wmem = 1'b1; t.wreg = 1'b0; end
            3: begin t.branch = 1'b1; t.wreg = 1'b0; end
            default: ;
        endcase
        return t;
    endfunction

    // Drive one instruction in the current (unstalled) cycle and follow it
    // through the stage, returning what was seen once it is presented.
    task automatic do_instr(input ins_t in, output obs_t o);
        int k = 0;
        bit done = 0;
        o.acc_req = 1'b0; o.acc_we = 1'b0; o.acc_addr = 32'd0; o.acc_wdata = 32'd0;
        drive(in);
        dif.dmem_rdata = in.rdata;
        dif.dmem_ready = 1'($urandom);  // stray ready while IDLE
        while (!done) begin
            @(negedge clk);
            if (mem_stall === 1'b1 && k < 600) begin
                k++;
                if (k == 1) begin
                    o.acc_req = dif.dmem_req; o.acc_we = dif.dmem_we;
                    o.acc_addr = dif.dmem_addr; o.acc_wdata = dif.dmem_wdata;
                end
                drive_junk();
                dif.dmem_ready = (k == in.ready_at);
            end else begin
                done = 1;
            end
        end
        if (k >= 600) begin
            tests++; fails++;
            $display("FAIL stall_bound: stall still high after %0d cycles, required release", k);
        end
        o.stall = k;
        o.valid = mem_valid; o.wreg = mem_wreg; o.m2reg = mem_m2reg; o.pcsrc = mem_pcsrc;
        o.err = mem_err; o.req_after = dif.dmem_req; o.aluR = mem_aluR; o.mdata = mem_mdata;
        o.bpc = mem_branch_pc; o.destR = mem_destR; o.typ = MEM_ins_type; o.num = MEM_ins_number;
        dif.dmem_ready = 1'($urandom);
    endtask

    task automatic test_reset();
        logic [180:0] outs;
        rst = 1'b0;
        drive_junk();
        dif.dmem_ready = 1'b1; dif.dmem_rdata = 32'hFFFF_FFFF;
        m_mdata = 32'd0; m_err = 1'b0;
        #3;
        outs = {mem_wreg, mem_m2reg, mem_aluR, mem_mdata, mem_destR, mem_pcsrc, mem_branch_pc,
                mem_stall, mem_valid, mem_err, MEM_ins_type, MEM_ins_number,
                dif.dmem_req, dif.dmem_we, dif.dmem_addr, dif.dmem_wdata};
        tests++;
        if (outs !== '0) begin fails++; $display("FAIL reset_outputs: got %h required 0", outs); end
        @(posedge clk); #1;
        outs = {mem_wreg, mem_m2reg, mem_aluR, mem_mdata, mem_destR, mem_pcsrc, mem_branch_pc,
                mem_stall, mem_valid, mem_err, MEM_ins_type, MEM_ins_number,
                dif.dmem_req, dif.dmem_we, dif.dmem_addr, dif.dmem_wdata};
        tests++;
        if (outs !== '0) begin fails++; $display("FAIL reset_held_edge: got %h required 0", outs); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_alu();
        ins_t t; obs_t o; int es; logic ew;
        t = mk(0); t.aluR = 32'h10; t.wreg = 1'b1; t.destR = 5'd5;
        model_step(t, es, ew);
        do_instr(t, o);
        tests++;
        if (o.stall !== 0 || o.valid !== 1'b1 || o.req_after !== 1'b0) begin
            fails++; $display("FAIL alu_flow: stall=%0d valid=%b req=%b required 0/1/0", o.stall, o.valid, o.req_after);
        end
        tests++;
        if (o.aluR !== 32'h10 || o.destR !== 5'd5 || o.wreg !== 1'b1) begin
            fails++; $display("FAIL alu_data: aluR=%h destR=%0d wreg=%b required 10/5/1", o.aluR, o.destR, o.wreg);
        end
    endtask

    task automatic test_load();
        ins_t t; obs_t o; int es; logic ew;
        t = mk(1); t.aluR = 32'h40; t.rdata = 32'hDEADBEEF; t.ready_at = 3;
        model_step(t, es, ew);
        do_instr(t, o);
        tests++;
        if (o.stall !== 3) begin fails++; $display("FAIL load_stall: got %0d required 3", o.stall); end
        tests++;
        if (o.acc_req !== 1'b1 || o.acc_we !== 1'b0 || o.acc_addr !== 32'h40) begin
            fails++; $display("FAIL load_bus: req=%b we=%b addr=%h required 1/0/40", o.acc_req, o.acc_we, o.acc_addr);
        end
        tests++;
        if (o.mdata !== 32'hDEADBEEF || o.valid !== 1'b1) begin
            fails++; $display("FAIL load_data: mdata=%h valid=%b required deadbeef/1", o.mdata, o.valid);
        end
    endtask

    task automatic test_store();
        ins_t t; obs_t o; int es; logic ew;
        t = mk(2); t.aluR = 32'h80; t.inB = 32'h1234; t.ready_at = 1;
        model_step(t, es, ew);
        do_instr(t, o);
        tests++;
        if (o.stall !== 1) begin fails++; $display("FAIL store_stall: got %0d required 1", o.stall); end
        tests++;
        if (o.acc_we !== 1'b1 || o.acc_addr !== 32'h80 || o.acc_wdata !== 32'h1234) begin
            fails++; $display("FAIL store_bus: we=%b addr=%h wdata=%h required 1/80/1234", o.acc_we, o.acc_addr, o.acc_wdata);
        end
        tests++;
        if (o.mdata !== 32'hDEADBEEF || o.req_after !== 1'b0) begin
            fails++; $display("FAIL store_hold: mdata=%h req=%b required deadbeef/0", o.mdata, o.req_after);
        end
    endtask

    task automatic test_ready_wins();
        ins_t t; obs_t o; int es; logic ew;
        t = mk(1); t.rdata = 32'hCAFE_0001; t.ready_at = WMAX;
        model_step(t, es, ew);
        do_instr(t, o);
        tests++;
        if (o.stall !== WMAX || o.err !== 1'b0 || o.mdata !== 32'hCAFE_0001 || o.wreg !== 1'b1) begin
            fails++; $display("FAIL ready_wins: stall=%0d err=%b mdata=%h wreg=%b required %0d/0/cafe0001/1",
                              o.stall, o.err, o.mdata, o.wreg, WMAX);
        end
    endtask

    task automatic test_branch();
        ins_t t; obs_t o; int es; logic ew;
        t = mk(3); t.zero = 1'b1; t.pc = 32'h200;
        model_step(t, es, ew);
        do_instr(t, o);
        tests++;
        if (o.pcsrc !== 1'b1 || o.bpc !== 32'h200 || o.stall !== 0) begin
            fails++; $display("FAIL branch_taken: pcsrc=%b pc=%h stall=%0d required 1/200/0", o.pcsrc, o.bpc, o.stall);
        end
        t.zero = 1'b0;
        model_step(t, es, ew);
        do_instr(t, o);
        tests++;
        if (o.pcsrc !== 1'b0 || o.bpc !== 32'h200) begin
            fails++; $display("FAIL branch_not_taken: pcsrc=%b pc=%h required 0/200", o.pcsrc, o.bpc);
        end
    endtask

    task automatic test_timeout();
        ins_t t; obs_t o; int es; logic ew;
        t = mk(1); t.wreg = 1'b1; t.ready_at = 0;
        model_step(t, es, ew);
        do_instr(t, o);
        tests++;
        if (o.stall !== WMAX || o.err !== 1'b1 || o.wreg !== 1'b0 || o.valid !== 1'b1) begin
            fails++; $display("FAIL timeout: stall=%0d err=%b wreg=%b valid=%b required %0d/1/0/1",
                              o.stall, o.err, o.wreg, o.valid, WMAX);
        end
        tests++;
        if (o.mdata !== m_mdata) begin
            fails++; $display("FAIL timeout_mdata: got %h required %h", o.mdata, m_mdata);
        end
        t = mk(0); t.wreg = 1'b1;
        model_step(t, es, ew);
        do_instr(t, o);
        tests++;
        if (o.wreg !== 1'b1 || o.err !== 1'b1) begin
            fails++; $display("FAIL timeout_next: wreg=%b err=%b required 1/1", o.wreg, o.err);
        end
    endtask

    task automatic test_random();
        ins_t t; obs_t o; int es; logic ew;
        for (int n = 0; n < 60; n++) begin
            t = mk($urandom_range(0, 3));
            model_step(t, es, ew);
            do_instr(t, o);
            tests++;
            if (o.stall !== es || o.wreg !== ew || o.err !== m_err || o.mdata !== m_mdata || o.valid !== 1'b1) begin
                fails++; $display("FAIL rand_ctrl[%0d]: stall=%0d wreg=%b err=%b mdata=%h valid=%b required %0d/%b/%b/%h/1",
                                  n, o.stall, o.wreg, o.err, o.mdata, o.valid, es, ew, m_err, m_mdata);
            end
            tests++;
            if ({o.m2reg, o.aluR, o.destR, o.pcsrc, o.bpc, o.typ, o.num, o.req_after} !==
                {t.m2reg, t.aluR, t.destR, t.branch & t.zero, t.pc, t.typ, t.num, 1'b0}) begin
                fails++; $display("FAIL rand_fields[%0d]: aluR=%h destR=%0d pcsrc=%b pc=%h tags=%h/%h required %h/%0d/%b/%h/%h/%h",
                                  n, o.aluR, o.destR, o.pcsrc, o.bpc, o.typ, o.num,
                                  t.aluR, t.destR, t.branch & t.zero, t.pc, t.typ, t.num);
            end
            if (t.m2reg || t.wmem) begin
                tests++;
                if (o.acc_req !== 1'b1 || o.acc_we !== t.wmem || o.acc_addr !== t.aluR || o.acc_wdata !== t.inB) begin
                    fails++; $display("FAIL rand_bus[%0d]: req=%b we=%b addr=%h wdata=%h required 1/%b/%h/%h",
                                      n, o.acc_req, o.acc_we, o.acc_addr, o.acc_wdata, t.wmem, t.aluR, t.inB);
                end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        ins_t t; obs_t o; int es; logic ew;
        logic [180:0] outs;
        logic req_before;
        t = mk(1); t.ready_at = 0;
        drive(t);
        dif.dmem_ready = 1'b0;
        @(negedge clk);            // first ACCESS cycle
        drive_junk();
        @(negedge clk);            // second ACCESS cycle
        req_before = dif.dmem_req;
        tests++;
        if (req_before !== 1'b1) begin fails++; $display("FAIL midrst_pre: req=%b required 1", req_before); end
        #2 rst = 1'b0;
        #1;
        outs = {mem_wreg, mem_m2reg, mem_aluR, mem_mdata, mem_destR, mem_pcsrc, mem_branch_pc,
                mem_stall, mem_valid, mem_err, MEM_ins_type, MEM_ins_number,
                dif.dmem_req, dif.dmem_we, dif.dmem_addr, dif.dmem_wdata};
        tests++;
        if (outs !== '0) begin fails++; $display("FAIL midrst_outputs: got %h required 0", outs); end
        m_mdata = 32'd0; m_err = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tests++;
        if (mem_stall !== 1'b0) begin fails++; $display("FAIL midrst_idle: stall=%b required 0", mem_stall); end
        t = mk(0); t.wreg = 1'b1;
        model_step(t, es, ew);
        do_instr(t, o);
        tests++;
        if (o.stall !== 0 || o.aluR !== t.aluR || o.wreg !== 1'b1 || o.err !== 1'b0 || o.mdata !== 32'd0) begin
            fails++; $display("FAIL midrst_after: stall=%0d aluR=%h wreg=%b err=%b mdata=%h required 0/%h/1/0/0",
                              o.stall, o.aluR, o.wreg, o.err, o.mdata, t.aluR);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_ready_wins();
        test_branch();
        test_timeout();
        test_random();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
